// File: rtl/ddr_rd_track_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_track_fifo
// Description : First-word-fall-through FIFO that tracks the tags of
//               outstanding DDR reads, with registered status and sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_track_fifo #(
    parameter int DATA_W   = 1,
    parameter int ADDR_W   = 8,
    parameter int AFULL_TH = 2**ADDR_W - 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_afull,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_ovf,
    output logic              o_udf,
    input  logic              i_clr_err
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              udf_set;

    // A pop while full frees a slot in the same cycle, so the push still lands.
    assign push_ok = i_push && (!o_full || i_pop);
    assign pop_ok  = i_pop && !o_empty;
    assign ovf_set = i_push && o_full && !i_pop;
    assign udf_set = i_pop && o_empty;

    always_comb begin
        count_nxt = o_count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = o_count + ONE_C;
            2'b01:   count_nxt = o_count - ONE_C;
            default: count_nxt = o_count;
        endcase
    end

    // Storage is intentionally left unreset; only entries below count are read.
    always_ff @(posedge i_clk) begin
        if (push_ok && i_rst_n) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            o_afull <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            o_count <= count_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == DEPTH_C);
            o_afull <= (count_nxt >= AFULL_C);
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            if (ovf_set) begin
                o_ovf <= 1'b1;
            end else if (i_clr_err) begin
                o_ovf <= 1'b0;
            end
            if (udf_set) begin
                o_udf <= 1'b1;
            end else if (i_clr_err) begin
                o_udf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
